// File: rtl/onchip_memory_dp_param_if.sv
// One Avalon-MM slave port of the dual-port on-chip RAM.
// The master modport drives commands; the slave modport returns data and back-pressure.
interface onchip_memory_dp_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13
);
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;

  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/onchip_memory_dp_param.sv
// True-dual-port on-chip RAM with two Avalon-MM slaves, pipelined reads,
// optional output register and a clear-on-reset sequencer.
module onchip_memory_dp_param #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 13,
  parameter int                    OUTREG         = 0,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,
  onchip_memory_dp_param_if.slave s1,
  onchip_memory_dp_param_if.slave s2,
  output logic                    init_done
);
  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  en, busy, clr_we;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] addr  [2];
  logic [NB-1:0]         be    [2];
  logic [DATA_WIDTH-1:0] wdata [2];
  logic                  wr    [2];
  logic                  rd    [2];
  logic [DATA_WIDTH-1:0] fwd   [2];
  logic                  v1_q  [2];
  logic [DATA_WIDTH-1:0] d1_q  [2];
  logic                  rvalid[2];
  logic [DATA_WIDTH-1:0] rdata [2];

  assign en        = clken & ~reset_req;
  assign busy      = reset | (state_q != S_RUN) | ~en;
  assign init_done = ~reset & (state_q == S_RUN);

  assign addr[0]  = s1.address;    assign addr[1]  = s2.address;
  assign be[0]    = s1.byteenable; assign be[1]    = s2.byteenable;
  assign wdata[0] = s1.writedata;  assign wdata[1] = s2.writedata;
  // A combined read+write command is taken as a write only.
  assign wr[0] = s1.chipselect & s1.write & ~busy;
  assign wr[1] = s2.chipselect & s2.write & ~busy;
  assign rd[0] = s1.chipselect & s1.read & ~s1.write & ~busy;
  assign rd[1] = s2.chipselect & s2.read & ~s2.write & ~busy;

  assign s1.waitrequest   = busy;
  assign s2.waitrequest   = busy;
  assign s1.readdata      = rdata[0];
  assign s2.readdata      = rdata[1];
  assign s1.readdatavalid = rvalid[0] & en;
  assign s2.readdatavalid = rvalid[1] & en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    if (en && !reset && state_q == S_CLEAR) begin
      clr_we = 1'b1;
      if (cnt_q == '1) state_d = S_RUN;
      else             cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (CLEAR_ON_RESET != 0) state_q <= S_CLEAR;
      else                     state_q <= S_RUN;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // s2 lanes are written first so that s1 wins on a shared enabled lane.
  always_ff @(posedge clk) begin
    if (clr_we) mem_q[cnt_q] <= CLEAR_VALUE;
    for (int unsigned i = 0; i < NB; i++) begin
      if (wr[1] && be[1][i]) mem_q[addr[1]][8*i +: 8] <= wdata[1][8*i +: 8];
      if (wr[0] && be[0][i]) mem_q[addr[0]][8*i +: 8] <= wdata[0][8*i +: 8];
    end
  end

  // Read value is the word as it will be after this cycle's writes.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      fwd[p] = mem_q[addr[p]];
      for (int unsigned i = 0; i < NB; i++) begin
        if (wr[1] && addr[1] == addr[p] && be[1][i]) fwd[p][8*i +: 8] = wdata[1][8*i +: 8];
        if (wr[0] && addr[0] == addr[p] && be[0][i]) fwd[p][8*i +: 8] = wdata[0][8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned p = 0; p < 2; p++) begin
        v1_q[p] <= 1'b0;
        d1_q[p] <= '0;
      end
    end else if (en) begin
      for (int unsigned p = 0; p < 2; p++) begin
        v1_q[p] <= rd[p];
        if (rd[p]) d1_q[p] <= fwd[p];
      end
    end
  end

  if (OUTREG != 0) begin : g_outreg
    logic                  v2_q [2];
    logic [DATA_WIDTH-1:0] d2_q [2];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int unsigned p = 0; p < 2; p++) begin
          v2_q[p] <= 1'b0;
          d2_q[p] <= '0;
        end
      end else if (en) begin
        for (int unsigned p = 0; p < 2; p++) begin
          v2_q[p] <= v1_q[p];
          if (v1_q[p]) d2_q[p] <= d1_q[p];
        end
      end
    end

    assign rvalid[0] = v2_q[0];
    assign rvalid[1] = v2_q[1];
    assign rdata[0]  = d2_q[0];
    assign rdata[1]  = d2_q[1];
  end else begin : g_direct
    assign rvalid[0] = v1_q[0];
    assign rvalid[1] = v1_q[1];
    assign rdata[0]  = d1_q[0];
    assign rdata[1]  = d1_q[1];
  end
endmodule

// File: tb/tb_onchip_memory_dp_param.sv
// Drives two instances (OUTREG=0 and OUTREG=1) with identical stimulus and
// checks them against a reference memory model and per-port read scoreboards.
module tb_onchip_memory_dp_param;
  localparam logic [31:0] CLR = 32'hA5A5A5A5;

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, clken, reset_req;
  logic        init_a, init_b;
  logic        c [2], r [2], w [2];
  logic [3:0]  ad [2], be [2];
  logic [31:0] wd [2];
  logic        vld [4];
  logic [31:0] rdat [4];
  logic [31:0] last [4];
  logic [31:0] mem_m [16];
  exp_t        q [4][$];
  exp_t        mon_e;
  int          ecnt   = 0;
  int          n_vec  = 0;
  int          n_fail = 0;

  onchip_memory_dp_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) a1 (), a2 (), b1 (), b2 ();

  assign {a1.chipselect, a1.read, a1.write, a1.address, a1.byteenable, a1.writedata} = {c[0], r[0], w[0], ad[0], be[0], wd[0]};
  assign {a2.chipselect, a2.read, a2.write, a2.address, a2.byteenable, a2.writedata} = {c[1], r[1], w[1], ad[1], be[1], wd[1]};
  assign {b1.chipselect, b1.read, b1.write, b1.address, b1.byteenable, b1.writedata} = {c[0], r[0], w[0], ad[0], be[0], wd[0]};
  assign {b2.chipselect, b2.read, b2.write, b2.address, b2.byteenable, b2.writedata} = {c[1], r[1], w[1], ad[1], be[1], wd[1]};

  assign vld[0] = a1.readdatavalid; assign rdat[0] = a1.readdata;
  assign vld[1] = a2.readdatavalid; assign rdat[1] = a2.readdata;
  assign vld[2] = b1.readdatavalid; assign rdat[2] = b1.readdata;
  assign vld[3] = b2.readdatavalid; assign rdat[3] = b2.readdata;

  onchip_memory_dp_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .OUTREG(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CLR)) dut_a (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .s1(a1), .s2(a2), .init_done(init_a));
  onchip_memory_dp_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .OUTREG(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CLR)) dut_b (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .s1(b1), .s2(b2), .init_done(init_b));

  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + ((clken && !reset_req) ? 1 : 0);

  function automatic logic [3:0] waits();
    return {a1.waitrequest, a2.waitrequest, b1.waitrequest, b2.waitrequest};
  endfunction

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %h, expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic rd_, input logic wr_, input logic [3:0] a,
                          input logic [3:0] b, input logic [31:0] d);
    c[p] = 1'b1; r[p] = rd_; w[p] = wr_; ad[p] = a; be[p] = b; wd[p] = d;
  endtask

  // Present the staged commands for one cycle; model writes, then queue reads.
  task automatic step();
    for (int p = 1; p >= 0; p--)
      if (c[p] && w[p])
        for (int i = 0; i < 4; i++)
          if (be[p][i]) mem_m[ad[p]][8*i +: 8] = wd[p][8*i +: 8];
    for (int p = 0; p < 2; p++)
      if (c[p] && r[p] && !w[p]) begin
        q[p].push_back('{mem_m[ad[p]], ecnt + 1});
        q[2+p].push_back('{mem_m[ad[p]], ecnt + 2});
      end
    #1;
    if (c[0] || c[1]) check("accept_wait", 0, 32'(waits()), 32'h0);
    @(posedge clk); #1;
    for (int p = 0; p < 2; p++) begin
      c[p] = 1'b0; r[p] = 1'b0; w[p] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic start_reset();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) q[k].delete();
    for (int a = 0; a < 16; a++) mem_m[a] = CLR;
  endtask

  task automatic clear_check();
    repeat (16) begin
      @(negedge clk);
      check("clr_wait", 0, 32'(waits()), 32'hF);
      check("clr_init", 0, 32'({init_a, init_b}), 32'h0);
    end
    @(negedge clk);
    check("init_done", 0, 32'({init_a, init_b}), 32'h3);
    check("run_wait", 0, 32'(waits()), 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) begin
      set_port(0, 1'b1, 1'b0, 4'(i), 4'h0, 32'h0);
      set_port(1, 1'b1, 1'b0, 4'(15 - i), 4'h0, 32'h0);
      step();
    end
    idle(4);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) last[k] = '0;
    end else if (clken && !reset_req) begin
      for (int k = 0; k < 4; k++) begin
        if (vld[k]) begin
          check("valid_expected", k, 32'(q[k].size() != 0), 32'd1);
          if (q[k].size() != 0) begin
            mon_e = q[k].pop_front();
            check("rdata", k, rdat[k], mon_e.d);
            check("latency", k, 32'(ecnt), 32'(mon_e.due));
            last[k] = mon_e.d;
          end
        end else begin
          check("rdata_hold", k, rdat[k], last[k]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clken = 1'b1;
    reset_req = 1'b0;
    for (int p = 0; p < 2; p++) begin
      c[p] = 1'b0; r[p] = 1'b0; w[p] = 1'b0; ad[p] = '0; be[p] = '0; wd[p] = '0;
    end
    start_reset();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_wait", 0, 32'(waits()), 32'hF);
    check("rst_valid", 0, 32'({vld[0], vld[1], vld[2], vld[3]}), 32'h0);
    check("rst_init", 0, 32'({init_a, init_b}), 32'h0);
    for (int k = 0; k < 4; k++) check("rst_rdata", k, rdat[k], 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Clear sequence, then every word reads back the fill value.
    clear_check();
    read_all();

    // Write then four back-to-back reads of the same word.
    set_port(0, 1'b0, 1'b1, 4'd3, 4'hF, 32'h12345678); step();
    repeat (4) begin
      set_port(0, 1'b1, 1'b0, 4'd3, 4'h0, 32'h0); step();
    end
    idle(3);

    // Byte enables.
    set_port(1, 1'b0, 1'b1, 4'd5, 4'hF, 32'hFFFFFFFF); step();
    set_port(0, 1'b0, 1'b1, 4'd5, 4'b0101, 32'h00000000); step();
    set_port(0, 1'b1, 1'b0, 4'd5, 4'h0, 32'h0); step();
    idle(3);

    // Same-address collisions and write-through forwarding.
    set_port(0, 1'b0, 1'b1, 4'd7, 4'hF, 32'h0); step();
    set_port(0, 1'b0, 1'b1, 4'd7, 4'b0011, 32'h11111111);
    set_port(1, 1'b0, 1'b1, 4'd7, 4'b0110, 32'h22222222); step();
    set_port(1, 1'b1, 1'b0, 4'd7, 4'h0, 32'h0); step();
    set_port(0, 1'b0, 1'b1, 4'd9, 4'hF, 32'hDEADBEEF);
    set_port(1, 1'b1, 1'b0, 4'd9, 4'h0, 32'h0); step();
    set_port(1, 1'b0, 1'b1, 4'd10, 4'b1001, 32'hCAFEF00D);
    set_port(0, 1'b1, 1'b0, 4'd10, 4'h0, 32'h0); step();
    set_port(0, 1'b1, 1'b1, 4'd11, 4'hF, 32'h13579BDF); step();
    set_port(1, 1'b1, 1'b0, 4'd11, 4'h0, 32'h0); step();
    idle(3);

    // Hold via reset_req with a read in flight.
    set_port(0, 1'b1, 1'b0, 4'd3, 4'h0, 32'h0); step();
    reset_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("hold_wait", 0, 32'(waits()), 32'hF);
      check("hold_valid", 0, 32'({vld[0], vld[1], vld[2], vld[3]}), 32'h0);
      @(posedge clk); #1;
    end
    reset_req = 1'b0;
    idle(4);

    // Dirty every word, then reset mid-flight and again mid-clear.
    for (int i = 0; i < 16; i++) begin
      set_port(0, 1'b0, 1'b1, 4'(i), 4'hF, 32'h10000000 + 32'(i)); step();
    end
    set_port(0, 1'b1, 1'b0, 4'd2, 4'h0, 32'h0); step();
    start_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    start_reset();
    @(negedge clk);
    check("midclr_init", 0, 32'({init_a, init_b}), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    clear_check();
    read_all();

    check("queues_drained", 0, 32'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
